// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD-to-binary converter: FSM encoding and BCD digit constants.
package bcd_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StConv,
    StDone
  } state_e;

  localparam int unsigned BCD_DIGIT_W   = 4;
  localparam int unsigned BCD_MAX_DIGIT = 9;

endpackage

// File: rtl/bcd_to_binary_if.sv
// Valid/ready bundle between a packed-BCD producer, the converter and the binary consumer.
interface bcd_to_binary_if
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS = 3,
  parameter int unsigned BIN_W  = 10
) ();

  logic [BCD_DIGIT_W*DIGITS-1:0] bcd_in;
  logic                          in_valid;
  logic                          in_ready;
  logic [BIN_W-1:0]              bnum;
  logic                          err;
  logic                          out_valid;
  logic                          out_ready;

  modport master (
    output bcd_in, in_valid, out_ready,
    input  in_ready, bnum, err, out_valid
  );

  modport slave (
    input  bcd_in, in_valid, out_ready,
    output in_ready, bnum, err, out_valid
  );

endinterface

// File: rtl/bcd_mac10.sv
// One Horner step for decimal accumulation: res = acc*10 + digit, wrapping at BIN_W bits.
module bcd_mac10
  import bcd_pkg::*;
#(
  parameter int unsigned BIN_W = 10
) (
  input  logic [BIN_W-1:0]       acc_i,
  input  logic [BCD_DIGIT_W-1:0] digit_i,
  output logic [BIN_W-1:0]       res_o
);

  always_comb begin
    res_o = (acc_i << 3) + (acc_i << 1) + BIN_W'(digit_i);
  end

endmodule

// File: rtl/bcd_to_binary.sv
// Digit-serial packed-BCD to binary converter, MSD first, one digit per clock.
module bcd_to_binary
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS = 3,
  parameter int unsigned BIN_W  = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  bcd_to_binary_if.slave   bus
);

  localparam int unsigned BcdW = BCD_DIGIT_W * DIGITS;
  localparam int unsigned CntW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  state_e            state_q, state_d;
  logic [BcdW-1:0]   shreg_q, shreg_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [BIN_W-1:0]  acc_q, acc_d;
  logic [BIN_W-1:0]  bnum_q, bnum_d;
  logic              err_q, err_d;
  logic [BIN_W-1:0]  mac_res;
  logic              nib_err;

  bcd_mac10 #(
    .BIN_W (BIN_W)
  ) u_mac10 (
    .acc_i   (acc_q),
    .digit_i (shreg_q[BcdW-1 -: BCD_DIGIT_W]),
    .res_o   (mac_res)
  );

  // Invalid nibbles are flagged at capture but still fed through the datapath as-is.
  always_comb begin
    nib_err = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (bus.bcd_in[i*BCD_DIGIT_W +: BCD_DIGIT_W] > BCD_DIGIT_W'(BCD_MAX_DIGIT)) begin
        nib_err = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    bnum_d  = bnum_q;
    err_d   = err_q;
    case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          shreg_d = bus.bcd_in;
          acc_d   = '0;
          cnt_d   = '0;
          err_d   = nib_err;
          state_d = StConv;
        end
      end
      StConv: begin
        acc_d   = mac_res;
        shreg_d = shreg_q << BCD_DIGIT_W;
        cnt_d   = cnt_q + CntW'(1);
        if (cnt_q == CntW'(DIGITS - 1)) begin
          bnum_d  = mac_res;
          state_d = StDone;
        end
      end
      StDone: begin
        if (bus.out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      shreg_q <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      bnum_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      bnum_q  <= bnum_d;
      err_q   <= err_d;
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = (state_q == StDone);
  assign bus.bnum      = bnum_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_bcd_to_binary.sv
// Randomized self-checking bench for bcd_to_binary against a positional-weight decimal model.
module tb_bcd_to_binary;

  localparam int unsigned DIGITS = 3;
  localparam int unsigned BIN_W  = 10;

  logic clk;
  logic rst_n;
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;

  bcd_to_binary_if #(.DIGITS(DIGITS), .BIN_W(BIN_W)) bus ();

  bcd_to_binary #(
    .DIGITS (DIGITS),
    .BIN_W  (BIN_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: sum of digit * 10^position, truncated to BIN_W bits.
  function automatic logic [BIN_W-1:0] ref_bnum(input logic [4*DIGITS-1:0] b);
    int s;
    int w;
    s = 0;
    w = 1;
    for (int k = 0; k < int'(DIGITS); k++) begin
      s = s + int'(b[k*4 +: 4]) * w;
      w = w * 10;
    end
    return BIN_W'(s);
  endfunction

  function automatic logic ref_err(input logic [4*DIGITS-1:0] b);
    for (int k = 0; k < int'(DIGITS); k++) begin
      if (b[k*4 +: 4] > 4'd9) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Advances until out_valid is seen; n counts edges taken, to flags an expired budget.
  task automatic wait_valid(output int n, output bit to);
    n = 0;
    while (!bus.out_valid && n < 20) begin
      tick();
      n++;
    end
    to = !bus.out_valid;
  endtask

  task automatic test_reset;
    vectors++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      $display("FAIL reset_hs: in_ready=%b out_valid=%b, want 1/0", bus.in_ready, bus.out_valid);
      miscompares++;
    end
    vectors++;
    if (bus.bnum !== '0 || bus.err !== 1'b0) begin
      $display("FAIL reset_out: bnum=%0d err=%b, want 0/0", bus.bnum, bus.err);
      miscompares++;
    end
    bus.in_valid = 1'b0;
    bus.bcd_in   = 12'h999;
    for (int i = 0; i < 4; i++) tick();
    vectors++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.bnum !== '0) begin
      $display("FAIL idle_hold: in_ready=%b out_valid=%b bnum=%0d, want 1/0/0",
               bus.in_ready, bus.out_valid, bus.bnum);
      miscompares++;
    end
  endtask

  task automatic test_basic;
    int n;
    bit to;
    bit rdy_bad;
    bus.bcd_in    = 12'h043;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    n = 1;
    rdy_bad = (bus.in_ready !== 1'b0);
    while (!bus.out_valid && n < 20) begin
      tick();
      n++;
      if (bus.in_ready !== 1'b0) rdy_bad = 1'b1;
    end
    // n counts edges from the accept edge (E0 is the first tick) to out_valid
    vectors++;
    if (n - 1 != int'(DIGITS)) begin
      $display("FAIL basic_latency: got %0d cycles, want %0d", n - 1, DIGITS);
      miscompares++;
    end
    vectors++;
    if (rdy_bad) begin
      $display("FAIL basic_in_ready: in_ready high during conversion, want 0");
      miscompares++;
    end
    vectors++;
    if (bus.bnum !== 10'd43 || bus.err !== 1'b0) begin
      $display("FAIL basic_value: bnum=%0d err=%b, want 43/0", bus.bnum, bus.err);
      miscompares++;
    end
    tick();
    vectors++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      $display("FAIL basic_handshake: in_ready=%b out_valid=%b, want 1/0",
               bus.in_ready, bus.out_valid);
      miscompares++;
    end
  endtask

  task automatic test_back_to_back;
    logic [11:0] vals [4];
    int prev;
    int n;
    bit to;
    vals[0] = 12'h999;
    vals[1] = 12'h000;
    vals[2] = 12'h021;
    vals[3] = 12'h030;
    prev = 0;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.bcd_in = vals[i];
      tick();
      if (i > 0) begin
        vectors++;
        if (cyc - prev != int'(DIGITS) + 2) begin
          $display("FAIL b2b_spacing[%0d]: got %0d cycles, want %0d", i, cyc - prev, DIGITS + 2);
          miscompares++;
        end
      end
      prev = cyc;
      wait_valid(n, to);
      vectors++;
      if (to || bus.bnum !== ref_bnum(vals[i]) || bus.err !== 1'b0) begin
        $display("FAIL b2b_value[%0d]: bnum=%0d err=%b timeout=%b, want %0d/0",
                 i, bus.bnum, bus.err, to, ref_bnum(vals[i]));
        miscompares++;
      end
      tick();
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic test_invalid;
    logic [11:0] vals [2];
    int n;
    bit to;
    vals[0] = 12'h0A5;
    vals[1] = 12'h007;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      bus.bcd_in   = vals[i];
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      wait_valid(n, to);
      vectors++;
      if (to || bus.bnum !== ref_bnum(vals[i]) || bus.err !== ref_err(vals[i])) begin
        $display("FAIL invalid[%0d]: bnum=%0d err=%b timeout=%b, want %0d/%b",
                 i, bus.bnum, bus.err, to, ref_bnum(vals[i]), ref_err(vals[i]));
        miscompares++;
      end
      tick();
    end
  endtask

  task automatic test_backpressure;
    int n;
    bit to;
    bit bad;
    bus.out_ready = 1'b0;
    bus.bcd_in    = 12'h123;
    bus.in_valid  = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    wait_valid(n, to);
    bad = to;
    for (int i = 0; i < 5; i++) begin
      bus.bcd_in   = 12'($urandom);
      bus.in_valid = 1'($urandom);
      tick();
      if (bus.bnum !== 10'd123 || bus.err !== 1'b0 || bus.out_valid !== 1'b1
          || bus.in_ready !== 1'b0) bad = 1'b1;
    end
    vectors++;
    if (bad) begin
      $display("FAIL backpressure_hold: bnum=%0d err=%b out_valid=%b in_ready=%b, want 123/0/1/0",
               bus.bnum, bus.err, bus.out_valid, bus.in_ready);
      miscompares++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    vectors++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      $display("FAIL backpressure_release: in_ready=%b out_valid=%b, want 1/0",
               bus.in_ready, bus.out_valid);
      miscompares++;
    end
  endtask

  task automatic test_reset_mid;
    int n;
    bit to;
    bus.out_ready = 1'b1;
    bus.bcd_in    = 12'h999;
    bus.in_valid  = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.bnum !== '0 || bus.in_ready !== 1'b1 || bus.err !== 1'b0) begin
      $display("FAIL reset_mid: out_valid=%b bnum=%0d in_ready=%b err=%b, want 0/0/1/0",
               bus.out_valid, bus.bnum, bus.in_ready, bus.err);
      miscompares++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    bus.bcd_in   = 12'h456;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    wait_valid(n, to);
    vectors++;
    if (to || bus.bnum !== 10'd456 || bus.err !== 1'b0) begin
      $display("FAIL reset_recover: bnum=%0d err=%b timeout=%b, want 456/0", bus.bnum, bus.err, to);
      miscompares++;
    end
    tick();
  endtask

  task automatic test_random;
    logic [11:0] b;
    int n;
    bit to;
    int hold;
    for (int i = 0; i < 30; i++) begin
      for (int k = 0; k < int'(DIGITS); k++) begin
        b[k*4 +: 4] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15))
                                                  : 4'($urandom_range(0, 9));
      end
      bus.out_ready = 1'($urandom);
      bus.bcd_in    = b;
      bus.in_valid  = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      bus.bcd_in   = 12'($urandom);
      wait_valid(n, to);
      vectors++;
      if (to || bus.bnum !== ref_bnum(b) || bus.err !== ref_err(b)) begin
        $display("FAIL random[%0d] bcd=%h: bnum=%0d err=%b timeout=%b, want %0d/%b",
                 i, b, bus.bnum, bus.err, to, ref_bnum(b), ref_err(b));
        miscompares++;
      end
      hold = $urandom_range(0, 3);
      for (int j = 0; j < hold; j++) begin
        bus.out_ready = 1'b0;
        tick();
      end
      bus.out_ready = 1'b1;
      tick();
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.bcd_in    = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    #22;
    rst_n = 1'b1;
    test_reset();
    test_basic();
    test_back_to_back();
    test_invalid();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bcd_to_binary.md
# bcd_to_binary

Sequential BCD-to-binary converter for the frequency-counter datapath. It is the inverse of the existing binary-to-BCD stage: packed BCD digits (for example, keypad or preset entry in hundreds/tens/ones form) are turned back into a binary count that the counter and compare logic can use. The conversion is digit-serial Horner accumulation, MSD first, one digit per clock. Valid/ready handshakes are used on both sides.

## Interface
Parameters:
- DIGITS, 3, number of BCD digits in the input word.
- BIN_W, 10, binary output width. Must satisfy 10^DIGITS − 1 < 2^BIN_W.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- bcd_in  input  4*DIGITS  packed BCD. Bits [4*DIGITS-1 -: 4] hold the MSD and bits [3:0] hold the ones digit.
- in_valid  input  1  bcd_in is valid.
- in_ready  output  1  converter is idle and can accept bcd_in.
- bnum  output  BIN_W  binary result.
- err  output  1  at least one captured nibble was greater than 9. Qualified by out_valid.
- out_valid  output  1  bnum and err are valid.
- out_ready  input  1  consumer accepts the result.

## Operation
- FSM states are IDLE, CONV and DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid: capture bcd_in into the digit shift register, clear acc, clear the digit counter cnt, latch err = OR over the digits of (nibble > 9), then go to CONV.
- CONV (in_ready = 0), on each clock:
  - acc <= acc*10 + top nibble. Implement ×10 as (acc<<3) + (acc<<1), with all arithmetic at BIN_W bits.
  - Shift the digit register left by 4 and increment cnt.
  - When cnt == DIGITS−1, load bnum <= the final acc value (the same-cycle result) and go to DONE.
- DONE:
  - out_valid = 1. bnum and err are held stable.
  - On out_ready: go to IDLE and drop out_valid.
- Invalid digits (nibble 0xA–0xF):
  - The conversion still runs, using the raw nibble value.
  - err = 1, and the result wraps modulo 2^BIN_W.
  - No other side effects.
- bnum is a dedicated register. It keeps the last completed result until the next conversion completes. It is not the working accumulator.
- in_ready is decoded combinationally from state == IDLE.
- bcd_in changes while the block is not in IDLE are ignored.

## Timing
- Reset values:
  - state = IDLE, so in_ready = 1.
  - out_valid = 0, bnum = 0, err = 0, acc = 0, cnt = 0.
- Reset mid-operation: asserting rst_n low in any state aborts the conversion immediately (asynchronously) and all registers return to their reset values.
- Accept happens at the rising edge where in_valid && in_ready. Call it edge E0.
- CONV occupies edges E1..E_DIGITS.
- out_valid is high from edge E_DIGITS onwards, so latency is DIGITS cycles from accept to out_valid (3 cycles at the default).
- The output handshake completes on the edge where out_valid && out_ready. After that edge, in_ready = 1.
- Minimum spacing between accepts is DIGITS+2 cycles; back-to-back conversions do not overlap.
- out_ready held high before DONE: the result is still presented for at least 1 cycle.
- out_ready held low: DONE persists indefinitely and bnum/err stay constant.
- in_valid low in IDLE: the block stays in IDLE and no registers change.

## Structure
- Shared package bcd_pkg holds:
  - the state encoding for IDLE, CONV and DONE;
  - BCD_DIGIT_W = 4;
  - BCD_MAX_DIGIT = 9.
- One combinational sub-module, bcd_mac10 (acc, digit → acc*10 + digit, BIN_W wide). It is reused by later multi-digit entry logic.
- The top level holds the FSM, the digit shift register, cnt (width clog2(DIGITS)), acc, the bnum register and the err register.

## Test plan
- Basic conversion and latency: after reset, bcd_in = 12'h043 with in_valid for 1 cycle and out_ready = 1.
  - Required: bnum = 43 and err = 0.
  - Required: out_valid rises exactly 3 cycles after the accept edge.
  - Required: in_ready is low from the accept edge until the handshake edge.
- Boundary values:
  - bcd_in = 12'h999 → bnum = 999.
  - bcd_in = 12'h000 → bnum = 0.
  - bcd_in = 12'h021 → bnum = 21.
  - bcd_in = 12'h030 → bnum = 30.
  - Run all four back-to-back with in_valid held high. Required: accepts are exactly DIGITS+2 cycles apart.
- Invalid digit: bcd_in = 12'h0A5.
  - Required: err = 1 and bnum = 105 (that is, 0*100 + 10*10 + 5).
  - Required: the next valid input 12'h007 gives err = 0.
- Backpressure: out_ready is held low for 5 cycles after out_valid rises.
  - Required: bnum and err are constant and bcd_in changes are ignored.
  - Required: on raising out_ready, the handshake happens on that edge and in_ready = 1 on the next cycle.
- Reset mid-conversion: assert rst_n low during the second CONV cycle of 12'h999.
  - Required: out_valid = 0, bnum = 0 and in_ready = 1 immediately.
  - Required: a subsequent 12'h456 gives bnum = 456.
